// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: EX-stage forwarding, multi-cycle
// load-use bubbles, data-memory wait freeze, taken-branch flush and saturating counters.
module hazard_ctrl #(
  parameter int unsigned REG_LENGTH      = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_LENGTH-1:0] rs1_d,
  input  logic [REG_LENGTH-1:0] rs2_d,
  input  logic [REG_LENGTH-1:0] rs1_e,
  input  logic [REG_LENGTH-1:0] rs2_e,
  input  logic [REG_LENGTH-1:0] rd_e,
  input  logic                  reg_write_e,
  input  logic                  is_load_e,
  input  logic                  pc_src_e,
  input  logic [REG_LENGTH-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic                  mem_req_m,
  input  logic                  mem_ready,
  input  logic [REG_LENGTH-1:0] rd_w,
  input  logic                  reg_write_w,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_events
);

  typedef enum logic [0:0] {StRun, StLuStall} state_e;

  localparam logic [2:0] LuInit = 3'(LOAD_USE_CYCLES - 1);

  state_e         r_state, w_state_next;
  logic [2:0]     r_bub_cnt, w_bub_next;
  logic [CNT_WIDTH-1:0] r_stall_cycles, r_flush_events;

  logic w_mem_wait, w_load_use, w_flush_evt;
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_d, w_flush_e;
  logic [1:0] w_fwd_a, w_fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [REG_LENGTH-1:0] rs,
                                         input logic [REG_LENGTH-1:0] dm, input logic wm,
                                         input logic [REG_LENGTH-1:0] dw, input logic ww);
    if (wm && (dm != '0) && (rs == dm))      return 2'b10;
    else if (ww && (dw != '0) && (rs == dw)) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign w_fwd_a    = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign w_fwd_b    = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign w_mem_wait = mem_req_m & ~mem_ready;
  assign w_load_use = is_load_e & reg_write_e & (rd_e != '0) &
                      ((rd_e == rs1_d) | (rd_e == rs2_d));

  always_comb begin
    w_state_next = r_state;
    w_bub_next   = r_bub_cnt;
    w_flush_evt  = 1'b0;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_stall_m    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    if (w_mem_wait) begin
      // Freeze the whole front end; bubble sequencing pauses with it.
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
    end else if (r_state == StRun) begin
      if (pc_src_e) begin
        w_flush_d   = 1'b1;
        w_flush_e   = 1'b1;
        w_flush_evt = 1'b1;
      end else if (w_load_use) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
        if (LOAD_USE_CYCLES > 1) begin
          w_state_next = StLuStall;
          w_bub_next   = LuInit;
        end
      end
    end else begin
      w_stall_f  = 1'b1;
      w_stall_d  = 1'b1;
      w_flush_e  = 1'b1;
      w_bub_next = r_bub_cnt - 3'd1;
      if (r_bub_cnt == 3'd1) w_state_next = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StRun;
      r_bub_cnt      <= 3'd0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bub_cnt <= w_bub_next;
      if (w_stall_d && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush_evt && (r_flush_events != '1)) r_flush_events <= r_flush_events + 1'b1;
    end
  end

  // Reset overrides the combinational outputs immediately, not just at the next edge.
  always_comb begin
    forward_a_e = rst_n ? w_fwd_a : 2'b00;
    forward_b_e = rst_n ? w_fwd_b : 2'b00;
    stall_f     = rst_n & w_stall_f;
    stall_d     = rst_n & w_stall_d;
    stall_e     = rst_n & w_stall_e;
    stall_m     = rst_n & w_stall_m;
    flush_d     = rst_n & w_flush_d;
    flush_e     = rst_n & w_flush_e;
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage RV32I core. It succeeds the purely combinational forwarding/stall unit with:
- configurable multi-cycle load-use bubbles;
- a data-memory wait freeze (mem_ready handshake);
- taken-branch flush;
- saturating performance counters.

It sits beside the datapath and drives the IF/ID/EX/MEM pipeline-register enables and flushes, plus the EX-stage forwarding muxes.

Parameters:
REG_LENGTH, 5, register index width
LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rs1_d  in  REG_LENGTH  decode-stage source 1
rs2_d  in  REG_LENGTH  decode-stage source 2
rs1_e  in  REG_LENGTH  execute-stage source 1
rs2_e  in  REG_LENGTH  execute-stage source 2
rd_e  in  REG_LENGTH  execute-stage destination
reg_write_e  in  1  EX instruction writes rd
is_load_e  in  1  EX instruction is a load
pc_src_e  in  1  taken branch/jump resolved in EX
rd_m  in  REG_LENGTH  memory-stage destination
reg_write_m  in  1  MEM instruction writes rd
mem_req_m  in  1  MEM stage accessing data memory
mem_ready  in  1  data memory completes this cycle
rd_w  in  REG_LENGTH  writeback destination
reg_write_w  in  1  WB instruction writes rd
forward_a_e  out  2  00 regfile, 10 from MEM, 01 from WB
forward_b_e  out  2  same encoding, source 2
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
stall_e  out  1  hold ID/EX
stall_m  out  1  hold EX/MEM
flush_d  out  1  clear IF/ID
flush_e  out  1  clear ID/EX (insert bubble)
stall_cycles  out  CNT_WIDTH  cycles with stall_d=1, saturating
flush_events  out  CNT_WIDTH  taken-branch flushes, saturating

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-low (rst_n).
- Forwarding (combinational), evaluated per source independently:
  - MEM match: rs==rd_m & reg_write_m & rd_m!=0 -> 10.
  - Otherwise WB match: rs==rd_w & reg_write_w & rd_w!=0 -> 01.
  - Otherwise 00.
  - MEM beats WB when both match.
- Hazard terms:
  - load_use = is_load_e & reg_write_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
  - mem_wait = mem_req_m & ~mem_ready.
- FSM states: RUN, LU_STALL. Down-counter bub_cnt, width 3.
- Priority, highest first:
  1. mem_wait: stall_f=stall_d=stall_e=stall_m=1; no flushes; FSM state and bub_cnt hold.
  2. RUN & pc_src_e: flush_d=flush_e=1, no stalls; flush_events++. A load_use in the same cycle is ignored because the decode instruction is squashed.
  3. RUN & load_use: stall_f=stall_d=1, flush_e=1. If LOAD_USE_CYCLES>1, go to LU_STALL with bub_cnt=LOAD_USE_CYCLES-1; otherwise stay in RUN.
  4. LU_STALL: stall_f=stall_d=1, flush_e=1; bub_cnt--. When bub_cnt==1 at the clock edge, return to RUN. pc_src_e is not evaluated in LU_STALL, since EX holds only bubbles.
  5. Otherwise: all stall/flush outputs = 0.
- Load-use bubbles total exactly LOAD_USE_CYCLES cycles, excluding freeze cycles.
- Counters:
  - stall_cycles increments on each rising edge where stall_d=1, including freeze cycles.
  - flush_events increments per taken-branch flush cycle.
  - Both saturate at all-ones and never wrap.
- Reset (rst_n low, at any time including mid-LU_STALL):
  - State -> RUN, bub_cnt=0, counters=0.
  - All stall/flush outputs forced 0.
  - Forwarding outputs forced 00.
  - Normal evaluation resumes on the first edge after deassertion.

Test Plan:
1. rd_m=5 with reg_write_m=1, and rd_w=5 with reg_write_w=1; rs1_e=5 -> forward_a_e=10. Clear reg_write_m -> 01. rs1_e=0 with rd_m=0 -> 00.
2. LOAD_USE_CYCLES=1: is_load_e=1, rd_e=3, rs2_d=3 -> exactly one cycle of stall_f=stall_d=flush_e=1; stall_cycles=1.
3. LOAD_USE_CYCLES=3: same stimulus -> three consecutive bubble cycles, then RUN. mem_wait asserted in cycle 2 for 4 cycles -> the bubble sequence pauses, all four stalls=1, resumes afterwards; stall_cycles=7.
4. pc_src_e=1 together with load_use=1 -> flush_d=flush_e=1, no stall; flush_events=1.
5. Drive stall_d for 2^CNT_WIDTH+3 cycles (CNT_WIDTH=4) -> stall_cycles holds at 15.
6. Assert rst_n=0 asynchronously mid-LU_STALL -> outputs 0 immediately; after release, no residual bubbles and counters=0.
